// File: rtl/pipeline_upsizer_if.sv
// Stream bundle for pipeline_upsizer: narrow input word stream plus wide packed output beat.
// slave  : seen by the upsizer (consumes data_in, produces data_out).
// master : seen by the producer/consumer side (bench or surrounding logic).
// Optional PIPELINE_UPSIZER_FLUSH_EN adds flush_i and data_out_count_o.
interface pipeline_upsizer_if #(
   parameter int DATAWIDTH = 32,
   parameter int RATIO     = 4
);
   logic [DATAWIDTH-1:0]       data_in_i;
   logic                       data_in_valid_i;
   logic                       data_in_ready_o;
   logic [RATIO*DATAWIDTH-1:0] data_out_o;
   logic                       data_out_valid_o;
   logic                       data_out_ready_i;
`ifdef PIPELINE_UPSIZER_FLUSH_EN
   logic                       flush_i;
   logic [$clog2(RATIO+1)-1:0] data_out_count_o;
`endif

   modport slave (
      input  data_in_i,
      input  data_in_valid_i,
      output data_in_ready_o,
      output data_out_o,
      output data_out_valid_o,
`ifdef PIPELINE_UPSIZER_FLUSH_EN
      input  flush_i,
      output data_out_count_o,
`endif
      input  data_out_ready_i
   );

   modport master (
      output data_in_i,
      output data_in_valid_i,
      input  data_in_ready_o,
      input  data_out_o,
      input  data_out_valid_o,
`ifdef PIPELINE_UPSIZER_FLUSH_EN
      output flush_i,
      input  data_out_count_o,
`endif
      output data_out_ready_i
   );
endinterface

// File: rtl/pipeline_upsizer.sv
// Packs RATIO consecutive DATAWIDTH-bit words into one RATIO*DATAWIDTH beat, word n in lane n.
// Ports: clk_i, arst_i (async, active-high), clear_i (sync flush), bus (pipeline_upsizer_if.slave).
// Latency: beat valid the cycle after the last word; full throughput, ready = not full or consumer ready.
// Option PIPELINE_UPSIZER_FLUSH_EN: flush_i promotes a partial beat (unfilled lanes zeroed) and
// data_out_count_o reports how many real words the presented beat holds.
module pipeline_upsizer #(
   parameter int DATAWIDTH = 32,
   parameter int RATIO     = 4
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              clear_i,
   pipeline_upsizer_if.slave bus
);
   localparam int            CW   = $clog2(RATIO+1);
   localparam logic [CW-1:0] FULL = CW'(RATIO);

   logic [DATAWIDTH-1:0] lanes [RATIO];
   logic [CW-1:0]        cnt;
   logic                 full;
   logic                 out_vld;
   logic                 in_rdy;
   logic                 in_fire;
   logic                 out_fire;
   logic                 wr_en;
   logic [CW-1:0]        wr_idx;

   assign full = (cnt == FULL);

`ifdef PIPELINE_UPSIZER_FLUSH_EN
   // Set once a partial beat has been promoted; cleared when that beat is taken.
   logic flushed;

   assign out_vld = full | flushed;
   // A promoted partial beat blocks new words until the consumer takes it.
   assign in_rdy  = flushed ? bus.data_out_ready_i : (~full | bus.data_out_ready_i);
`else
   assign out_vld = full;
   assign in_rdy  = ~full | bus.data_out_ready_i;
`endif

   assign in_fire  = bus.data_in_valid_i & in_rdy;
   assign out_fire = out_vld & bus.data_out_ready_i;

   // When the held beat leaves on the same edge a word arrives, that word restarts at lane 0.
   assign wr_idx = out_fire ? '0 : cnt;
   assign wr_en  = in_fire & ~clear_i;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         for (int k = 0; k < RATIO; k++) lanes[k] <= '0;
      end else if (wr_en) begin
         for (int k = 0; k < RATIO; k++) begin
            if (wr_idx == CW'(k)) lanes[k] <= bus.data_in_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         cnt <= '0;
      end else if (clear_i) begin
         cnt <= '0;
      end else if (in_fire) begin
         cnt <= wr_idx + 1'b1;
      end else if (out_fire) begin
         cnt <= '0;
      end
   end

`ifdef PIPELINE_UPSIZER_FLUSH_EN
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         flushed <= 1'b0;
      end else if (clear_i || out_fire) begin
         flushed <= 1'b0;
      end else if (bus.flush_i && (cnt != '0) && !full && !flushed) begin
         // Any word accepted this edge is already packed by the cnt/lane update above.
         flushed <= 1'b1;
      end
   end

   // Lanes at or beyond the real word count read as zero; a normal beat has cnt==RATIO.
   always_comb begin
      bus.data_out_o = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (CW'(k) < cnt) bus.data_out_o[k*DATAWIDTH +: DATAWIDTH] = lanes[k];
      end
   end

   assign bus.data_out_count_o = out_vld ? cnt : '0;
`else
   always_comb begin
      bus.data_out_o = '0;
      for (int k = 0; k < RATIO; k++) begin
         bus.data_out_o[k*DATAWIDTH +: DATAWIDTH] = lanes[k];
      end
   end
`endif

   assign bus.data_out_valid_o = out_vld;
   assign bus.data_in_ready_o  = in_rdy;
endmodule

// File: tb/tb_pipeline_upsizer.sv
// Directed and randomized checks for pipeline_upsizer (DATAWIDTH=32, RATIO=4).
module tb_pipeline_upsizer;
   localparam int DW = 32;
   localparam int R  = 4;
   localparam int BW = DW*R;

   logic clk   = 1'b0;
   logic arst  = 1'b1;
   logic clear = 1'b0;

   pipeline_upsizer_if #(.DATAWIDTH(DW), .RATIO(R)) bus ();

   pipeline_upsizer #(.DATAWIDTH(DW), .RATIO(R)) dut (
      .clk_i   (clk),
      .arst_i  (arst),
      .clear_i (clear),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one input cycle, then return 1ns after the edge that samples it.
   task automatic put(input logic vld, input logic [DW-1:0] d, input logic rdy);
      bus.data_in_valid_i  = vld;
      bus.data_in_i        = d;
      bus.data_out_ready_i = rdy;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BW-1:0] pack4(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                           input logic [DW-1:0] w2, input logic [DW-1:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   logic [DW-1:0] q[$];
   logic [BW-1:0] exp_beat;
   int            beats;
   logic          r_vld, r_rdy, r_clr, infire, outfire;
   logic [DW-1:0] r_dat;

   initial begin
      bus.data_in_i        = '0;
      bus.data_in_valid_i  = 1'b0;
      bus.data_out_ready_i = 1'b0;
`ifdef PIPELINE_UPSIZER_FLUSH_EN
      bus.flush_i          = 1'b0;
`endif
      // ---- reset state ----
      #2;
      check("rst_vld",  bus.data_out_valid_o, 0);
      check("rst_rdy",  bus.data_in_ready_o,  1);
      check("rst_data", bus.data_out_o,       0);
      @(negedge clk);
      arst = 1'b0;
      @(posedge clk); #1;

      // ---- reset mid-stream with cnt=2 ----
      put(1, 32'hAA, 0);
      put(1, 32'hBB, 0);
      bus.data_in_valid_i = 1'b0;
      #2 arst = 1'b1;
      #1;
      check("midrst_vld",  bus.data_out_valid_o, 0);
      check("midrst_rdy",  bus.data_in_ready_o,  1);
      check("midrst_data", bus.data_out_o,       0);
      @(negedge clk);
      arst = 1'b0;
      #1;
      check("postrst_vld",  bus.data_out_valid_o, 0);
      check("postrst_rdy",  bus.data_in_ready_o,  1);
      check("postrst_data", bus.data_out_o,       0);
      @(posedge clk); #1;

      // ---- continuous stream ----
      put(1, 32'h11, 1);
      put(1, 32'h22, 1);
      put(1, 32'h33, 1);
      check("cont_vld_early", bus.data_out_valid_o, 0);
      put(1, 32'h44, 1);
      check("cont_vld",  bus.data_out_valid_o, 1);
      check("cont_beat", bus.data_out_o, 128'h00000044_00000033_00000022_00000011);
      check("cont_rdy_full", bus.data_in_ready_o, 1);
      put(1, 32'h55, 1);
      check("cont_nobubble_vld", bus.data_out_valid_o, 0);
      put(1, 32'h66, 1);
      put(1, 32'h77, 1);
      put(1, 32'h88, 1);
      check("cont2_vld",  bus.data_out_valid_o, 1);
      check("cont2_beat", bus.data_out_o, pack4(32'h55, 32'h66, 32'h77, 32'h88));
      put(0, 32'h0, 1);
      check("cont_drain_vld", bus.data_out_valid_o, 0);

      // ---- backpressure ----
      put(1, 32'h01, 0);
      put(1, 32'h02, 0);
      put(1, 32'h03, 0);
      put(1, 32'h04, 0);
      for (int i = 0; i < 5; i++) begin
         check("bp_vld",  bus.data_out_valid_o, 1);
         check("bp_rdy",  bus.data_in_ready_o,  0);
         check("bp_beat", bus.data_out_o, pack4(32'h01, 32'h02, 32'h03, 32'h04));
         put(1, 32'hEE, 0);
      end
      bus.data_out_ready_i = 1'b1;
      #1;
      check("bp_rdy_release", bus.data_in_ready_o, 1);
      put(1, 32'h55, 1);
      check("bp_after_vld", bus.data_out_valid_o, 0);
      put(1, 32'h56, 1);
      put(1, 32'h57, 1);
      put(1, 32'h58, 1);
      check("bp_lane0_beat", bus.data_out_o, pack4(32'h55, 32'h56, 32'h57, 32'h58));
      put(0, 32'h0, 1);

      // ---- synchronous clear ----
      put(1, 32'hC1, 1);
      put(1, 32'hC2, 1);
      put(1, 32'hC3, 1);
      clear = 1'b1;
      put(1, 32'h99, 1);
      clear = 1'b0;
      check("clr_vld", bus.data_out_valid_o, 0);
      put(1, 32'hA0, 1);
      put(1, 32'hA1, 1);
      put(1, 32'hA2, 1);
      check("clr_vld_early", bus.data_out_valid_o, 0);
      put(1, 32'hA3, 1);
      check("clr_beat_vld", bus.data_out_valid_o, 1);
      check("clr_beat", bus.data_out_o, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3));
      put(0, 32'h0, 1);
      check("clr_single_beat", bus.data_out_valid_o, 0);

`ifdef PIPELINE_UPSIZER_FLUSH_EN
      // ---- flush of a partial beat ----
      put(1, 32'h1, 0);
      put(1, 32'h2, 0);
      bus.flush_i = 1'b1;
      put(0, 32'h0, 0);
      bus.flush_i = 1'b0;
      check("flush_vld",   bus.data_out_valid_o, 1);
      check("flush_beat",  bus.data_out_o, pack4(32'h1, 32'h2, 32'h0, 32'h0));
      check("flush_count", bus.data_out_count_o, 2);
      check("flush_rdy",   bus.data_in_ready_o, 0);
      put(0, 32'h0, 1);
      check("flush_taken_vld",   bus.data_out_valid_o, 0);
      check("flush_taken_count", bus.data_out_count_o, 0);
      bus.flush_i = 1'b1;
      put(0, 32'h0, 1);
      bus.flush_i = 1'b0;
      check("flush_empty_ignored", bus.data_out_valid_o, 0);
`endif

      // ---- randomized traffic against a word-queue model ----
      q.delete();
      beats = 0;
      for (int c = 0; c < 1000; c++) begin
         r_vld = 1'($urandom_range(0, 1));
         r_rdy = 1'($urandom_range(0, 1));
         r_clr = ($urandom_range(0, 99) < 5);
         r_dat = $urandom;
         bus.data_in_valid_i  = r_vld;
         bus.data_in_i        = r_dat;
         bus.data_out_ready_i = r_rdy;
         clear                = r_clr;
         #2;
         check("rnd_vld", bus.data_out_valid_o, (q.size() == R));
         check("rnd_rdy", bus.data_in_ready_o,  (q.size() < R) || r_rdy);
         infire  = r_vld & bus.data_in_ready_o;
         outfire = bus.data_out_valid_o & r_rdy;
         if (outfire) begin
            if (q.size() >= R) begin
               exp_beat = pack4(q[0], q[1], q[2], q[3]);
               check("rnd_beat", bus.data_out_o, exp_beat);
               for (int i = 0; i < R; i++) void'(q.pop_front());
            end
            beats++;
         end
         if (r_clr) q.delete();
         else if (infire) q.push_back(r_dat);
         @(posedge clk); #1;
      end
      clear = 1'b0;
      check("rnd_beats_seen", (beats > 20), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
